// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane count, lane index mapping, loader FSM encoding
// and parameter legality checks.
package keccak_pkg;

  localparam int NUM_LANES = 25;

  typedef enum logic [1:0] {
    ABSORB    = 2'd0,
    HANDOFF   = 2'd1,
    WAIT_PERM = 2'd2
  } loader_state_e;

  function automatic int lane_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

  function automatic bit lane_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic bit rate_legal(input int r);
    return (r >= 1) && (r <= 24);
  endfunction

endpackage

// File: rtl/keccak_lane_pack.sv
// Combinational flat-vector <-> lane-array conversion, lane (x,y) at bits
// [(5*y+x)*LANE_W +: LANE_W]; zero latency, no flow control.
module keccak_lane_pack
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [NUM_LANES*LANE_W-1:0] i_flat,
  output logic [LANE_W-1:0]           o_lanes [0:NUM_LANES-1],
  input  logic [LANE_W-1:0]           i_lanes [0:NUM_LANES-1],
  output logic [NUM_LANES*LANE_W-1:0] o_flat
);

  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
      localparam int IDX = lane_idx(x, y);
      assign o_lanes[IDX]                   = i_flat[IDX*LANE_W +: LANE_W];
      assign o_flat[IDX*LANE_W +: LANE_W]   = i_lanes[IDX];
    end
  end

endmodule

// File: rtl/keccak_absorb_loader.sv
// Absorbs message lanes into the Keccak rate, hands the state to the permutation,
// reloads the result. Block ready 1 cycle after last beat; s_ready low outside ABSORB.
module keccak_absorb_loader
  import keccak_pkg::*;
#(
  parameter int LANE_W     = 64,
  parameter int RATE_LANES = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANE_W-1:0]           s_data,
  input  logic                        s_last,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic                        blk_last,
  output logic [NUM_LANES*LANE_W-1:0] state_out,
  input  logic                        perm_valid,
  input  logic [NUM_LANES*LANE_W-1:0] perm_state
);

  localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

  if (!lane_w_legal(LANE_W)) begin : g_bad_lane_w
    $error("keccak_absorb_loader: LANE_W must be 8, 16, 32 or 64");
  end
  if (!rate_legal(RATE_LANES)) begin : g_bad_rate
    $error("keccak_absorb_loader: RATE_LANES must be in 1..24");
  end

  logic [LANE_W-1:0] r_lanes      [0:NUM_LANES-1];
  logic [LANE_W-1:0] w_perm_lanes [0:NUM_LANES-1];
  logic [CNT_W-1:0]  r_cnt;
  loader_state_e     r_fsm;
  logic              r_blk_valid;
  logic              r_blk_last;

  // One instance packs the held state outward and unpacks the returned permutation.
  keccak_lane_pack #(.LANE_W(LANE_W)) u_pack (
    .i_flat  (perm_state),
    .o_lanes (w_perm_lanes),
    .i_lanes (r_lanes),
    .o_flat  (state_out)
  );

  assign s_ready   = (r_fsm == ABSORB);
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_LANES; i++) r_lanes[i] <= '0;
      r_cnt       <= '0;
      r_fsm       <= ABSORB;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
    end else begin
      case (r_fsm)
        ABSORB: begin
          if (s_valid) begin
            // Loop bound keeps capacity lanes out of reach of s_data.
            for (int i = 0; i < RATE_LANES; i++) begin
              if (r_cnt == CNT_W'(i)) r_lanes[i] <= r_lanes[i] ^ s_data;
            end
            if (r_cnt == CNT_W'(RATE_LANES - 1) || s_last) begin
              r_cnt       <= '0;
              r_fsm       <= HANDOFF;
              r_blk_valid <= 1'b1;
              r_blk_last  <= s_last;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HANDOFF: begin
          if (blk_ready) begin
            r_blk_valid <= 1'b0;
            r_fsm       <= WAIT_PERM;
          end
        end
        WAIT_PERM: begin
          if (perm_valid) begin
            for (int i = 0; i < NUM_LANES; i++) r_lanes[i] <= w_perm_lanes[i];
            r_blk_last <= 1'b0;
            r_fsm      <= ABSORB;
          end
        end
        default: r_fsm <= ABSORB;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_absorb_loader.sv
// Directed bench for keccak_absorb_loader at LANE_W=64, RATE_LANES=17.
module tb_keccak_absorb_loader;

  localparam int LW = 64;
  localparam int SW = 25 * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [LW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          blk_last;
  logic [SW-1:0] state_out;
  logic          perm_valid = 1'b0;
  logic [SW-1:0] perm_state = '0;

  int n_cmp = 0;
  int n_bad = 0;

  keccak_absorb_loader #(.LANE_W(LW), .RATE_LANES(17)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_last   (blk_last),
    .state_out  (state_out),
    .perm_valid (perm_valid),
    .perm_state (perm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lane(input int i);
    return state_out[i*LW +: LW];
  endfunction

  // Present one beat; returns at the next negedge, after it was taken.
  task automatic beat(input logic [LW-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL reset_state got %h exp 0", state_out); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL reset_blk_valid got %b exp 0", blk_valid); end
    n_cmp++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL reset_blk_last got %b exp 0", blk_last); end
  endtask

  task automatic test_full_block;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid got %b exp 0", blk_valid); end
      end
      beat(LW'(i + 1), 1'b0);
    end
    n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL full_blk_valid got %b exp 1", blk_valid); end
    n_cmp++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL full_blk_last got %b exp 0", blk_last); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_s_ready got %b exp 0", s_ready); end
    for (int i = 0; i < 25; i++) begin
      logic [LW-1:0] e;
      e = (i < 17) ? LW'(i + 1) : '0;
      n_cmp++; if (lane(i) !== e) begin n_bad++; $display("FAIL full_lane%0d got %h exp %h", i, lane(i), e); end
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL full_after_hs_valid got %b exp 0", blk_valid); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_wait_s_ready got %b exp 0", s_ready); end
    perm_state = '0;
    perm_valid = 1'b1;
    @(negedge clk);
    perm_valid = 1'b0;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL full_perm_s_ready got %b exp 1", s_ready); end
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL full_perm_state got %h exp 0", state_out); end
  endtask

  task automatic test_short_and_hold;
    logic [SW-1:0] exp_st;
    exp_st = '0;
    for (int i = 0; i < 3; i++) exp_st[i*LW +: LW] = 64'hAAAA_AAAA_AAAA_AAAA;
    for (int i = 0; i < 3; i++) beat(64'hAAAA_AAAA_AAAA_AAAA, i == 2);
    n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL short_blk_valid got %b exp 1", blk_valid); end
    n_cmp++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL short_blk_last got %b exp 1", blk_last); end
    n_cmp++; if (state_out !== exp_st) begin n_bad++; $display("FAIL short_state got %h exp %h", state_out, exp_st); end
    // Stall in HANDOFF with spurious perm_valid pulses.
    perm_state = '1;
    for (int c = 0; c < 5; c++) begin
      perm_valid = c[0];
      @(negedge clk);
      n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL hold_blk_valid c%0d got %b exp 1", c, blk_valid); end
      n_cmp++; if (state_out !== exp_st) begin n_bad++; $display("FAIL hold_state c%0d got %h exp %h", c, state_out, exp_st); end
    end
    perm_valid = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    perm_valid = 1'b1;
    @(negedge clk);
    perm_valid = 1'b0;
    n_cmp++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL perm_blk_last got %b exp 0", blk_last); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL perm_s_ready got %b exp 1", s_ready); end
    beat(64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    n_cmp++; if (lane(0) !== 64'hF0F0_F0F0_F0F0_F0F0) begin n_bad++; $display("FAIL reload_lane0 got %h exp f0f0f0f0f0f0f0f0", lane(0)); end
    for (int i = 1; i < 25; i++) begin
      n_cmp++; if (lane(i) !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL reload_lane%0d got %h exp ffffffffffffffff", i, lane(i)); end
    end
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL reload_blk_valid got %b exp 0", blk_valid); end
  endtask

  task automatic test_clear;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL clear_idle_state got %h exp 0", state_out); end
    for (int i = 0; i < 5; i++) beat(LW'(8'h11 * (i + 1)), 1'b0);
    n_cmp++; if (lane(4) !== 64'h55) begin n_bad++; $display("FAIL clear_pre_lane4 got %h exp 55", lane(4)); end
    clear = 1'b1;
    s_valid = 1'b1;
    s_data = 64'hDEAD;
    @(negedge clk);
    clear = 1'b0;
    s_valid = 1'b0;
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL clear_beat_state got %h exp 0", state_out); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL clear_s_ready got %b exp 1", s_ready); end
    beat(64'h77, 1'b1);
    n_cmp++; if (lane(0) !== 64'h77) begin n_bad++; $display("FAIL clear_cnt_lane0 got %h exp 77", lane(0)); end
    n_cmp++; if (lane(1) !== 64'h0) begin n_bad++; $display("FAIL clear_cnt_lane1 got %h exp 0", lane(1)); end
    n_cmp++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL clear_blk_last got %b exp 1", blk_last); end
    // Clear in WAIT_PERM with a coincident perm_valid.
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    clear = 1'b1;
    perm_valid = 1'b1;
    perm_state = '1;
    @(negedge clk);
    clear = 1'b0;
    perm_valid = 1'b0;
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL clear_perm_state got %h exp 0", state_out); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL clear_perm_s_ready got %b exp 1", s_ready); end
    n_cmp++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL clear_perm_blk_last got %b exp 0", blk_last); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) beat(64'hC0DE_0000 + LW'(i), 1'b0);
    n_cmp++; if (lane(3) !== 64'hC0DE_0003) begin n_bad++; $display("FAIL mid_pre_lane3 got %h exp c0de0003", lane(3)); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL mid_rst_state got %h exp 0", state_out); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_s_ready got %b exp 1", s_ready); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_blk_valid got %b exp 0", blk_valid); end
    // perm_valid outside WAIT_PERM must not load the state.
    perm_state = '1;
    perm_valid = 1'b1;
    @(negedge clk);
    perm_valid = 1'b0;
    n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL absorb_perm_ignored got %h exp 0", state_out); end
    // Counter restarted at lane 0 after reset.
    beat(64'h9, 1'b1);
    n_cmp++; if (lane(0) !== 64'h9) begin n_bad++; $display("FAIL mid_rst_cnt_lane0 got %h exp 9", lane(0)); end
    n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rst_blk_valid2 got %b exp 1", blk_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_block();
    test_short_and_hold();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
